// File: rtl/mem_bank_sched_pkg.sv
// Shared constants and address decoding for the four-bank memory front end.
// Bank select sits on byte-address bits [2:1]; the row is everything above bit 2.
package mem_bank_sched_pkg;

  localparam int NUM_BANKS     = 4;
  localparam int BANK_LSB      = 1;
  localparam int BANK_MSB      = 2;
  localparam int ROW_LSB       = 3;
  localparam int RD_LATENCY    = 2;
  localparam int BANK_BUSY_DEF = 4;
  localparam int MAX_ADDR_W    = 32;

  typedef struct packed {
    logic [BANK_MSB-BANK_LSB:0]    bank;
    logic [MAX_ADDR_W-ROW_LSB-1:0] row;
  } addr_fields_t;

  // Callers zero-extend their address to MAX_ADDR_W and keep the row bits they need.
  function automatic addr_fields_t split_addr(input logic [MAX_ADDR_W-1:0] a);
    addr_fields_t f;
    f.bank = a[BANK_MSB:BANK_LSB];
    f.row  = a[MAX_ADDR_W-1:ROW_LSB];
    return f;
  endfunction

endpackage

// File: rtl/mem_bank_timer.sv
// Per-bank busy timer: loadable down-counter that saturates at zero.
// busy_o is high while the count is non-zero.
module mem_bank_timer #(
  parameter int BUSY_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The accept cycle counts as the first busy cycle, hence the minus one.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(BUSY_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/mem_bank_sched.sv
// Four-bank interleaved memory front end with per-bank busy stalls and a fixed
// two-cycle read return. Define MEM_ERR_CHECK_EN to reject rd&wr and odd addresses.
module mem_bank_sched
  import mem_bank_sched_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int BANK_BUSY  = BANK_BUSY_DEF,
  parameter int BANK_WORDS = 2 ** (ADDR_W - 3)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 rd_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int ROW_W = ADDR_W - ROW_LSB;

  addr_fields_t                     fields;
  logic [BANK_MSB-BANK_LSB:0]       bank;
  logic [ROW_W-1:0]                 row;
  logic [MAX_ADDR_W-ADDR_W-1:0]     unused_row_hi;
  logic                             req;
  logic                             illegal;
  logic                             accept;
  logic                             wr_acc;
  logic                             rd_acc;
  logic [NUM_BANKS-1:0]             load;
  logic [DATA_W-1:0]                rdata;
  logic [DATA_W-1:0]                mem_q [NUM_BANKS][BANK_WORDS];
  logic [RD_LATENCY-1:0]            vld_q;
  logic [DATA_W-1:0]                dat_q [RD_LATENCY];

  assign fields        = split_addr(MAX_ADDR_W'(addr));
  assign bank          = fields.bank;
  assign row           = fields.row[ROW_W-1:0];
  assign unused_row_hi = fields.row[MAX_ADDR_W-ROW_LSB-1:ROW_W];

  assign req = rd | wr;

`ifdef MEM_ERR_CHECK_EN
  assign illegal = (rd & wr) | (req & addr[0]);
  assign err     = rst & illegal;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  // stall ignores illegal: an illegal request is flagged and dropped, never held.
  assign stall  = req & busy[bank];
  assign accept = rst & req & ~busy[bank] & ~illegal;
  assign wr_acc = accept & wr;
  assign rd_acc = accept & rd & ~wr;

  always_comb begin
    load       = '0;
    load[bank] = accept;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_timer
    mem_bank_timer #(
      .BUSY_CYCLES (BANK_BUSY),
      .CNT_W       (3)
    ) u_timer (
      .clk    (clk),
      .rst_n  (rst),
      .load_i (load[b]),
      .busy_o (busy[b])
    );
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[bank][row] <= data_in;
    end
  end

  assign rdata = mem_q[bank][row];

  // Stage data is zeroed when no read was accepted so data_out idles at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q    <= {vld_q[RD_LATENCY-2:0], rd_acc};
      dat_q[0] <= rd_acc ? rdata : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign data_out = dat_q[RD_LATENCY-1];
  assign rd_valid = vld_q[RD_LATENCY-1];

endmodule

// File: tb/tb_mem_bank_sched.sv
// Self-checking bench for mem_bank_sched: directed cases plus random traffic,
// scored against a reference model of bank free-times and a word-addressed memory.
`timescale 1ns/1ps
module tb_mem_bank_sched;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int BANK_BUSY = 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              stall;
  logic [3:0]        busy;
  logic              err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bank_sched #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BANK_BUSY (BANK_BUSY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  // ---------------- reference model state ----------------
  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                exp_cyc_q[$];
  logic [DATA_W-1:0] mem_m [logic [ADDR_W-1:0]];
  int                free_at [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_illegal(input logic r, input logic w, input logic [ADDR_W-1:0] a);
`ifdef MEM_ERR_CHECK_EN
    return (r & w) | ((r | w) & a[0]);
`else
    return 1'b0 & a[0] & r & w;
`endif
  endfunction

  function automatic logic [3:0] model_busy();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (free_at[i] > cyc);
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  // Present one request and hold it until accepted or dropped as illegal.
  task automatic issue(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, output int stalls);
    logic              req;
    logic              ill;
    logic              acc;
    logic [3:0]        bexp;
    int                b;
    logic [ADDR_W-1:0] key;
    bit                fin;
    fin    = 1'b0;
    stalls = 0;
    for (int t = 0; t < 16 && !fin; t++) begin
      @(negedge clk);
      rd = r; wr = w; addr = a; data_in = d;
      #1;
      req  = r | w;
      b    = int'(a[2:1]);
      bexp = model_busy();
      ill  = model_illegal(r, w, a);
      check("busy", busy, bexp);
      check("stall", stall, req & bexp[b]);
      check("err", err, ill);
      acc = req & ~bexp[b] & ~ill;
      key = {a[ADDR_W-1:1], 1'b0};
      if (acc) begin
        if (w) begin
          mem_m[key] = d;
        end else begin
          exp_q.push_back(mem_m.exists(key) ? mem_m[key] : '0);
          exp_cyc_q.push_back(cyc + 2);
        end
        free_at[b] = cyc + BANK_BUSY;
        fin = 1'b1;
      end else if (ill) begin
        fin = 1'b1;
      end else begin
        stalls++;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=stalled expected=accept addr=%0h", a);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      #1;
      check("idle_busy", busy, model_busy());
      check("idle_stall", stall, 1'b0);
      check("idle_err", err, 1'b0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic              exp_valid;
    logic [DATA_W-1:0] d;
    forever begin
      @(posedge clk);
      #2;
      exp_valid = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      check("rd_valid", rd_valid, exp_valid);
      if (exp_valid) begin
        d = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        check("data_out", data_out, d);
      end else begin
        check("data_out_idle", data_out, '0);
      end
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int total;
    logic r;
    logic w;
    logic [ADDR_W-1:0] a;
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    for (int i = 0; i < 4; i++) free_at[i] = 0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", busy, 4'b0000);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_data_out", data_out, '0);
    check("reset_stall", stall, 1'b0);
    check("reset_err", err, 1'b0);
    rst = 1'b1;

    // Preload a small window so every later read has a known value.
    for (int i = 0; i < 32; i++) begin
      issue(1'b0, 1'b1, ADDR_W'(i * 2), DATA_W'($urandom), s);
      check("preload_stalls", s, 0);
    end
    idle(4);

    // Write then read back through the two-cycle pipeline.
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, s);
    idle(4);
    issue(1'b1, 1'b0, 16'h0010, '0, s);
    idle(4);

    // Consecutive banks stream with no stall.
    total = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, ADDR_W'(i * 2), '0, s);
      total += s;
    end
    check("stream_stalls", total, 0);
    idle(4);

    // Same bank back-to-back: three stall cycles.
    issue(1'b1, 1'b0, 16'h0008, '0, s);
    issue(1'b1, 1'b0, 16'h0018, '0, s);
    check("same_bank_stalls", s, BANK_BUSY - 1);
    idle(6);

    // Reset while a read is in flight: it must never return.
    issue(1'b1, 1'b0, 16'h0014, '0, s);
    @(negedge clk);
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    #1;
    check("midreset_busy", busy, 4'b0000);
    check("midreset_rd_valid", rd_valid, 1'b0);
    @(negedge clk);
    #1;
    check("midreset_rd_valid_n2", rd_valid, 1'b0);
    check("midreset_data_out_n2", data_out, '0);
    check("midreset_busy_n2", busy, 4'b0000);
    rst = 1'b1;
    idle(2);

    // Odd-address write: rejected with the error check, lands at the even word without.
    issue(1'b0, 1'b1, 16'h0021, 16'h5A5A, s);
    check("odd_write_stalls", s, 0);
    idle(4);
    issue(1'b1, 1'b0, 16'h0020, '0, s);
    idle(4);

    // rd&wr together: rejected, or treated as a plain write with no return.
    issue(1'b1, 1'b1, 16'h0030, 16'h1234, s);
    idle(4);
    issue(1'b1, 1'b0, 16'h0030, '0, s);
    idle(4);

    // Random traffic over the preloaded window.
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 9);
      a  = ADDR_W'($urandom_range(0, 31) * 2);
      r  = (op <= 4);
      w  = (op >= 5 && op <= 8);
      if (op == 9) begin
        if ($urandom_range(0, 1) == 1) begin
          a = a | 16'h0001;
          r = 1'b0; w = 1'b1;
        end else begin
          r = 1'b1; w = 1'b1;
        end
      end
      issue(r, w, a, DATA_W'($urandom), s);
      if ($urandom_range(0, 2) == 0) idle(1);
    end

    idle(6);
    check("drain_exp_q", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
